// File: rtl/quad_encoder_gen_pkg.sv
// Shared types, (a,b) phase patterns and counter limits for the quadrature encoder emulator.
package quad_gen_pkg;

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4} step_state_t;
  typedef enum logic [1:0] {B_IDLE, B_LOW, B_GAP} btn_state_t;

  // (a,b) per phase packed as {S4,S3,S2,S1}; both rest at 11 in S4.
  localparam logic [7:0] CW_AB  = {2'b11, 2'b10, 2'b00, 2'b01};
  localparam logic [7:0] CCW_AB = {2'b11, 2'b01, 2'b00, 2'b10};

  function automatic int sat_limit(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic logic [1:0] phase_ab(input step_state_t st, input logic ccw_dir);
    logic [7:0] pat;
    pat = ccw_dir ? CCW_AB : CW_AB;
    case (st)
      S1:      return pat[1:0];
      S2:      return pat[3:2];
      S3:      return pat[5:4];
      S4:      return pat[7:6];
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Down-counting phase timer: load starts a TICKS-cycle interval, expired marks its last cycle.
module tick_timer #(
  parameter int TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(TICKS - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns cw/ccw/prs pulses into held a/b/btn levels,
// with a saturating signed queue of pending steps and an independent button sequencer.
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int PHASE_TICKS = 10000,
  parameter int PRESS_TICKS = 10000,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cw,
  input  logic ccw,
  input  logic prs,
  output logic a,
  output logic b,
  output logic btn,
  output logic busy,
  output logic ovf
);

  localparam int SW  = CNT_W + 2;
  localparam int LIM = sat_limit(CNT_W);
  localparam logic signed [SW-1:0] ONE   = SW'(1);
  localparam logic signed [SW-1:0] M_ONE = SW'(-1);
  localparam logic signed [SW-1:0] LIM_P = SW'(LIM);
  localparam logic signed [SW-1:0] LIM_N = SW'(-LIM);

  step_state_t st_q, st_d;
  btn_state_t  bst_q, bst_d;
  logic signed [CNT_W-1:0] pend_q, pend_d;
  logic dir_q, dir_d;
  logic a_q, a_d, b_q, b_d, btn_q, btn_d, busy_q, busy_d, ovf_q, ovf_d;
  logic ph_load, ph_exp, pr_load, pr_exp;
  logic deq, step_ovf, btn_ovf;
  logic signed [SW-1:0] req_v, deq_v, sum;

  tick_timer #(.TICKS(PHASE_TICKS)) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (ph_load),
    .expired (ph_exp)
  );

  tick_timer #(.TICKS(PRESS_TICKS)) u_press_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (pr_load),
    .expired (pr_exp)
  );

  // Step FSM: a new step is taken from the queue on leaving IDLE or on S4 expiry.
  always_comb begin
    st_d    = st_q;
    dir_d   = dir_q;
    ph_load = 1'b0;
    deq     = 1'b0;
    case (st_q)
      IDLE: begin
        if (pend_q != '0) begin
          st_d    = S1;
          dir_d   = pend_q[CNT_W-1];
          ph_load = 1'b1;
          deq     = 1'b1;
        end
      end
      S1: if (ph_exp) begin st_d = S2; ph_load = 1'b1; end
      S2: if (ph_exp) begin st_d = S3; ph_load = 1'b1; end
      S3: if (ph_exp) begin st_d = S4; ph_load = 1'b1; end
      S4: begin
        if (ph_exp) begin
          if (pend_q != '0) begin
            st_d    = S1;
            dir_d   = pend_q[CNT_W-1];
            ph_load = 1'b1;
            deq     = 1'b1;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Request and dequeue are netted in a widened sum before clamping.
  always_comb begin
    req_v = '0;
    if (cw && !ccw) req_v = ONE;
    if (ccw && !cw) req_v = M_ONE;
    deq_v = '0;
    if (deq) deq_v = pend_q[CNT_W-1] ? M_ONE : ONE;
    sum      = SW'(pend_q) + req_v - deq_v;
    step_ovf = 1'b0;
    pend_d   = $signed(sum[CNT_W-1:0]);
    if (sum > LIM_P) begin
      pend_d   = CNT_W'(LIM);
      step_ovf = 1'b1;
    end else if (sum < LIM_N) begin
      pend_d   = CNT_W'(-LIM);
      step_ovf = 1'b1;
    end
  end

  always_comb begin
    bst_d   = bst_q;
    pr_load = 1'b0;
    btn_ovf = 1'b0;
    case (bst_q)
      B_IDLE: begin
        if (prs) begin
          bst_d   = B_LOW;
          pr_load = 1'b1;
        end
      end
      B_LOW: begin
        btn_ovf = prs;
        if (pr_exp) begin
          bst_d   = B_GAP;
          pr_load = 1'b1;
        end
      end
      B_GAP: begin
        btn_ovf = prs;
        if (pr_exp) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they change on the same edge as the FSMs.
  always_comb begin
    {a_d, b_d} = phase_ab(st_d, dir_d);
    btn_d      = (bst_d != B_LOW);
    busy_d     = (st_d != IDLE) || (pend_d != '0) || (bst_d != B_IDLE);
    ovf_d      = step_ovf | btn_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      bst_q  <= B_IDLE;
      pend_q <= '0;
      dir_q  <= 1'b0;
      a_q    <= 1'b1;
      b_q    <= 1'b1;
      btn_q  <= 1'b1;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      bst_q  <= bst_d;
      pend_q <= pend_d;
      dir_q  <= dir_d;
      a_q    <= a_d;
      b_q    <= b_d;
      btn_q  <= btn_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign btn  = btn_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
